// File: rtl/llc_output_encoder.sv
// LLC transmit-side encoder: steers one message per cycle into four per-channel FIFOs
// (rsp, fwd, mem, dma). Optional handshake counters are built with LLC_OUT_STATS_EN.
module llc_output_encoder #(
    parameter int DEPTH  = 2,
    parameter int MSG_W  = 5,
    parameter int ADDR_W = 26,
    parameter int DATA_W = 128,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_chan,
    input  logic [MSG_W-1:0]  in_msg,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DEST_W-1:0] in_dest,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [MSG_W-1:0]  rsp_msg,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic [DEST_W-1:0] rsp_dest,
    output logic              fwd_valid,
    input  logic              fwd_ready,
    output logic [MSG_W-1:0]  fwd_msg,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [DEST_W-1:0] fwd_dest,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [MSG_W-1:0]  mem_msg,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [DEST_W-1:0] mem_dest,
    output logic              dma_valid,
    input  logic              dma_ready,
    output logic [MSG_W-1:0]  dma_msg,
    output logic [ADDR_W-1:0] dma_addr,
    output logic [DATA_W-1:0] dma_data,
    output logic [DEST_W-1:0] dma_dest,
    output logic              empty,
    output logic [15:0]       stat_rsp_cnt,
    output logic [15:0]       stat_fwd_cnt,
    output logic [15:0]       stat_mem_cnt,
    output logic [15:0]       stat_dma_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = MSG_W + ADDR_W + DATA_W + DEST_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    // Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1;
    // the producer holds valid and its fields stable until that edge, ready may toggle freely.
    logic [ENT_W-1:0] store [4][DEPTH];
    logic [PTR_W-1:0] wptr  [4];
    logic [PTR_W-1:0] rptr  [4];
    logic [CNT_W-1:0] count [4];
    logic [ENT_W-1:0] head  [4];
    logic [ENT_W-1:0] in_entry;
    logic [3:0]       push, pop, c_valid, c_ready;

    assign in_entry = {in_msg, in_addr, in_data, in_dest};
    assign c_ready  = {dma_ready, mem_ready, fwd_ready, rsp_ready};
    // Full test ignores a same-cycle pop: no fall-through path from ready to in_ready.
    assign in_ready = (count[in_chan] != FULL);

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            c_valid[c] = (count[c] != '0);
            push[c]    = in_valid && in_ready && (in_chan == 2'(c));
            pop[c]     = c_valid[c] && c_ready[c];
            head[c]    = store[c][rptr[c]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < 4; c++) begin
                wptr[c]  <= '0;
                rptr[c]  <= '0;
                count[c] <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    store[c][e] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (push[c]) begin
                    store[c][wptr[c]] <= in_entry;
                    wptr[c]           <= wptr[c] + PTR_W'(1);
                end
                if (pop[c]) begin
                    rptr[c] <= rptr[c] + PTR_W'(1);
                end
                if (push[c] && !pop[c]) begin
                    count[c] <= count[c] + CNT_W'(1);
                end else if (!push[c] && pop[c]) begin
                    count[c] <= count[c] - CNT_W'(1);
                end
            end
        end
    end

    assign {rsp_valid, fwd_valid, mem_valid, dma_valid} =
           {c_valid[0], c_valid[1], c_valid[2], c_valid[3]};
    assign {rsp_msg, rsp_addr, rsp_data, rsp_dest} = head[0];
    assign {fwd_msg, fwd_addr, fwd_data, fwd_dest} = head[1];
    assign {mem_msg, mem_addr, mem_data, mem_dest} = head[2];
    assign {dma_msg, dma_addr, dma_data, dma_dest} = head[3];

    assign empty = (c_valid == 4'b0000);

`ifdef LLC_OUT_STATS_EN
    logic [15:0] stat_q [4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < 4; c++) begin
                stat_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (pop[c] && (stat_q[c] != 16'hFFFF)) begin
                    stat_q[c] <= stat_q[c] + 16'd1;
                end
            end
        end
    end

    assign stat_rsp_cnt = stat_q[0];
    assign stat_fwd_cnt = stat_q[1];
    assign stat_mem_cnt = stat_q[2];
    assign stat_dma_cnt = stat_q[3];
`else
    assign stat_rsp_cnt = '0;
    assign stat_fwd_cnt = '0;
    assign stat_mem_cnt = '0;
    assign stat_dma_cnt = '0;
`endif

    a_chan_known: assert property (@(posedge clk) disable iff (!rst)
        in_valid |-> !$isunknown(in_chan));

    for (genvar g = 0; g < 4; g++) begin : g_chk
        a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
            !(push[g] && (count[g] == FULL)));
        a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
            !(pop[g] && (count[g] == '0)));
    end

endmodule

// File: tb/tb_llc_output_encoder.sv
// Scoreboard bench for llc_output_encoder: the driver queues expected entries per channel,
// a monitor checks valid/empty every cycle and compares head fields against the queue.
module tb_llc_output_encoder;
    localparam int MSG_W  = 5;
    localparam int ADDR_W = 26;
    localparam int DATA_W = 128;
    localparam int DEST_W = 4;
    localparam int ENT_W  = MSG_W + ADDR_W + DATA_W + DEST_W;
`ifdef LLC_OUT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0, in_ready;
    logic [1:0] in_chan = '0;
    logic [MSG_W-1:0] in_msg = '0;
    logic [ADDR_W-1:0] in_addr = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic [DEST_W-1:0] in_dest = '0;
    logic rsp_valid, fwd_valid, mem_valid, dma_valid;
    logic rsp_ready = 1'b0, fwd_ready = 1'b0, mem_ready = 1'b0, dma_ready = 1'b0;
    logic [MSG_W-1:0] rsp_msg, fwd_msg, mem_msg, dma_msg;
    logic [ADDR_W-1:0] rsp_addr, fwd_addr, mem_addr, dma_addr;
    logic [DATA_W-1:0] rsp_data, fwd_data, mem_data, dma_data;
    logic [DEST_W-1:0] rsp_dest, fwd_dest, mem_dest, dma_dest;
    logic empty;
    logic [15:0] stat_rsp_cnt, stat_fwd_cnt, stat_mem_cnt, stat_dma_cnt;

    llc_output_encoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan),
        .in_msg(in_msg), .in_addr(in_addr), .in_data(in_data), .in_dest(in_dest),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_msg(rsp_msg),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_dest(rsp_dest),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_msg(fwd_msg),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_dest(fwd_dest),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_msg(mem_msg),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_dest(mem_dest),
        .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_msg(dma_msg),
        .dma_addr(dma_addr), .dma_data(dma_data), .dma_dest(dma_dest),
        .empty(empty),
        .stat_rsp_cnt(stat_rsp_cnt), .stat_fwd_cnt(stat_fwd_cnt),
        .stat_mem_cnt(stat_mem_cnt), .stat_dma_cnt(stat_dma_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [ENT_W-1:0] exp_q [4][$];
    int n_vec = 0;
    int n_fail = 0;
    int hs [4] = '{0, 0, 0, 0};
    logic [3:0] vld, rdy;
    logic [ENT_W-1:0] hd [4];

    assign vld = {dma_valid, mem_valid, fwd_valid, rsp_valid};
    assign rdy = {dma_ready, mem_ready, fwd_ready, rsp_ready};
    assign hd[0] = {rsp_msg, rsp_addr, rsp_data, rsp_dest};
    assign hd[1] = {fwd_msg, fwd_addr, fwd_data, fwd_dest};
    assign hd[2] = {mem_msg, mem_addr, mem_data, mem_dest};
    assign hd[3] = {dma_msg, dma_addr, dma_data, dma_dest};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit all_q_empty();
        return (exp_q[0].size() == 0) && (exp_q[1].size() == 0) &&
               (exp_q[2].size() == 0) && (exp_q[3].size() == 0);
    endfunction

    // monitor: compare on the falling edge, retire expected entries at the rising edge
    initial begin
        logic [3:0] pend;
        forever begin
            @(negedge clk);
            pend = '0;
            if (rst) begin
                for (int c = 0; c < 4; c++) begin
                    check($sformatf("valid_ch%0d", c), vld[c], exp_q[c].size() != 0);
                    if (vld[c] && exp_q[c].size() != 0) begin
                        check($sformatf("head_ch%0d", c), hd[c], exp_q[c][0]);
                        pend[c] = rdy[c];
                    end
                end
                check("empty_flag", empty, all_q_empty());
            end
            @(posedge clk);
            for (int c = 0; c < 4; c++) begin
                if (pend[c] && rst) begin
                    void'(exp_q[c].pop_front());
                    hs[c]++;
                end
            end
        end
    end

    // driver tasks
    task automatic send(input logic [1:0] ch, input logic [MSG_W-1:0] m,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [DEST_W-1:0] ds, output int stall);
        stall = 0;
        in_valid = 1'b1; in_chan = ch; in_msg = m; in_addr = a; in_data = d; in_dest = ds;
        @(negedge clk);
        while (!in_ready && stall < 100) begin
            stall++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("send_accept_timeout", in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q[ch].push_back({m, a, d, ds});
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (!(all_q_empty() && empty) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", empty, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state();
        check("rst_valids", vld, 4'b0000);
        check("rst_empty", empty, 1'b1);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_fields", {rsp_addr, fwd_data, mem_msg, dma_dest}, '0);
        check("rst_stats", {stat_rsp_cnt, stat_fwd_cnt, stat_mem_cnt, stat_dma_cnt}, '0);
    endtask

    function automatic logic [DATA_W-1:0] mk_data(input int i);
        return {32'hDA7A0000 + 32'(i), 32'(i) * 32'd3, 32'hC0DE0000 ^ 32'(i), 32'(i)};
    endfunction

    initial begin
        int st;
        logic [ADDR_W-1:0] a_mem [3];
        a_mem[0] = 26'h00A0A0; a_mem[1] = 26'h00B0B0; a_mem[2] = 26'h00C0C0;

        // reset then single fwd send
        #12;
        check_reset_state();
        @(posedge clk); #1 rst = 1'b1;
        fwd_ready = 1'b1;
        check("idle_empty", empty, 1'b1);
        send(2'd1, 5'd3, 26'h1234, mk_data(1), 4'd2, st);
        check("fwd_stall", st, 0);
        @(negedge clk);
        check("fwd_valid_after_accept", fwd_valid, 1'b1);
        check("fwd_addr", fwd_addr, 26'h1234);
        check("empty_busy", empty, 1'b0);
        @(negedge clk);
        check("empty_after_pop", empty, 1'b1);
        @(posedge clk); #1;

        // reset mid-operation
        fwd_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            send(2'd0, 5'(i + 4), 26'(16'h5000 + i), mk_data(10 + i), 4'd1, st);
            send(2'd1, 5'(i + 8), 26'(16'h6000 + i), mk_data(20 + i), 4'd3, st);
        end
        check("full_rsp_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) exp_q[c].delete();
        hs = '{0, 0, 0, 0};
        #1 check_reset_state();
        @(posedge clk); #1 rst = 1'b1;
        fwd_ready = 1'b1;
        send(2'd1, 5'd7, 26'h2345, mk_data(30), 4'd5, st);
        check("post_reset_stall", st, 0);
        drain();

        // back-pressure, full, independence
        rsp_ready = 1'b0; mem_ready = 1'b0;
        send(2'd2, 5'd1, a_mem[0], mk_data(40), 4'd6, st);
        check("mem0_stall", st, 0);
        send(2'd2, 5'd2, a_mem[1], mk_data(41), 4'd6, st);
        check("mem1_stall", st, 0);
        send(2'd0, 5'd9, 26'h3333, mk_data(42), 4'd7, st);
        check("rsp_while_mem_full_stall", st, 0);
        @(negedge clk);
        check("rsp_valid_indep", rsp_valid, 1'b1);
        check("mem_valid_held", mem_valid, 1'b1);
        check("mem_addr_held", mem_addr, a_mem[0]);
        @(posedge clk); #1;
        fork
            send(2'd2, 5'd3, a_mem[2], mk_data(43), 4'd6, st);
            begin
                repeat (3) @(posedge clk);
                #1 mem_ready = 1'b1;
            end
        join
        check("mem2_stall_cycles", st, 4);
        rsp_ready = 1'b1;
        drain();

        // simultaneous push/pop with pointer wrap on dma
        dma_ready = 1'b0;
        send(2'd3, 5'd0, 26'h7000, mk_data(50), 4'd8, st);
        dma_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(2'd3, 5'(i), 26'(16'h7000 + i), mk_data(50 + i), 4'(8 + i), st);
            check($sformatf("dma_stream_stall_%0d", i), st, 0);
        end
        drain();
        check("stat_fwd_mid", stat_fwd_cnt, STATS ? 16'd1 : 16'd0);
        check("stat_mem_mid", stat_mem_cnt, STATS ? 16'd3 : 16'd0);
        check("stat_dma_mid", stat_dma_cnt, STATS ? 16'd9 : 16'd0);
        check("stat_rsp_mid", stat_rsp_cnt, STATS ? 16'd1 : 16'd0);

        // rsp counter saturation
        rsp_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            send(2'd0, 5'(i), 26'(i), mk_data(i), 4'(i), st);
        end
        drain();
        check("stat_rsp_sat", stat_rsp_cnt, STATS ? 16'hFFFF : 16'h0);
        check("stat_rsp_model", stat_rsp_cnt, STATS ? ((hs[0] > 65535) ? 16'hFFFF : 16'(hs[0])) : 16'h0);
        check("stat_fwd_final", stat_fwd_cnt, STATS ? 16'(hs[1]) : 16'h0);
        check("stat_mem_final", stat_mem_cnt, STATS ? 16'(hs[2]) : 16'h0);
        check("stat_dma_final", stat_dma_cnt, STATS ? 16'(hs[3]) : 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
